// File: rtl/sseg_scan_controller.sv
// Purpose : 4-digit seven-segment scanner with per-slot blanking gap, hex decode,
//           decimal points, optional leading-zero suppression and tear-free update.
// Latency : an/sseg/frame_tick are registered and change on the same edge as the
//           scan state. An accepted update is shown from digit 0 of the next frame.
// Backpressure: upd_ready drops for the cycle after an accept. It returns once the
//           pending update has been committed at the following frame boundary.
// Ports   : clk, reset (sync, active-high); hex_in/dp_in/en_in + upd_valid/upd_ready
//           update handshake; an (active-low anodes), sseg (active-low {dp,g..a}),
//           frame_tick (1-cycle pulse at the start of each frame).
module sseg_scan_controller #(
    parameter int DIGIT_CYCLES = 262144,
    parameter int BLANK_CYCLES = 1024,
    parameter int LZ_BLANK     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_in,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_tick
);

    localparam int CW = $clog2(DIGIT_CYCLES);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;

    logic [15:0]   hex_act_q, hex_pend_q;
    logic [3:0]    dp_act_q, dp_pend_q;
    logic [3:0]    en_act_q, en_pend_q;
    logic          pend_vld_q, pend_vld_d;

    logic [3:0]    an_q, an_d;
    logic [7:0]    sseg_q, sseg_d;
    logic          frame_tick_q, frame_tick_d;

    logic          slot_last;
    logic          boundary;
    logic          capture;
    logic [3:0]    vis;
    logic [3:1]    hi_zero;
    logic [3:0]    digit_nib;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    // hi_zero[i]: digit i and everything to its left carry neither a non-zero
    // nibble nor a lit decimal point, i.e. digit i is a leading zero.
    assign hi_zero[3] = (hex_act_q[15:12] == 4'h0) && !dp_act_q[3];
    assign hi_zero[2] = hi_zero[3] && (hex_act_q[11:8] == 4'h0) && !dp_act_q[2];
    assign hi_zero[1] = hi_zero[2] && (hex_act_q[7:4]  == 4'h0) && !dp_act_q[1];

    assign vis[0] = en_act_q[0];
    assign vis[1] = en_act_q[1] && !((LZ_BLANK != 0) && hi_zero[1]);
    assign vis[2] = en_act_q[2] && !((LZ_BLANK != 0) && hi_zero[2]);
    assign vis[3] = en_act_q[3] && !((LZ_BLANK != 0) && hi_zero[3]);

    assign slot_last = (cnt_q == CW'(DIGIT_CYCLES - 1));
    assign boundary  = (state_q == ST_SHOW) && slot_last && (idx_q == 2'd3);
    assign capture   = upd_valid && !pend_vld_q;
    assign digit_nib = hex_act_q[{idx_d, 2'b00} +: 4];

    // Next-state and registered-output logic. Outputs are computed from the
    // next state so pins switch on the same edge as the scan state.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = slot_last ? '0 : cnt_q + CW'(1);
        an_d         = 4'hF;
        sseg_d       = 8'hFF;
        frame_tick_d = boundary;
        pend_vld_d   = pend_vld_q;

        case (state_q)
            ST_BLANK: if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
            ST_SHOW: begin
                if (slot_last) begin
                    state_d = ST_BLANK;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // active regs only change at a boundary, where the next state is
        // BLANK, so reading the current active regs here is safe
        if (state_d == ST_SHOW && vis[idx_d]) begin
            an_d[idx_d] = 1'b0;
            sseg_d      = {~dp_act_q[idx_d], seg7(digit_nib)};
        end

        if (boundary && pend_vld_q) pend_vld_d = 1'b0;
        else if (capture)           pend_vld_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            an_q         <= 4'hF;
            sseg_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
            pend_vld_q   <= 1'b0;
            hex_pend_q   <= 16'h0;
            dp_pend_q    <= 4'h0;
            en_pend_q    <= 4'h0;
            hex_act_q    <= 16'h0;
            dp_act_q     <= 4'h0;
            en_act_q     <= 4'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_tick_d;
            pend_vld_q   <= pend_vld_d;
            // capture can only happen while nothing is pending, so it never
            // collides with the commit below
            if (capture) begin
                hex_pend_q <= hex_in;
                dp_pend_q  <= dp_in;
                en_pend_q  <= en_in;
            end
            if (boundary && pend_vld_q) begin
                hex_act_q <= hex_pend_q;
                dp_act_q  <= dp_pend_q;
                en_act_q  <= en_pend_q;
            end
        end
    end

    assign upd_ready  = !pend_vld_q;
    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
module tb_sseg_scan_controller;

    localparam int DC = 8;
    localparam int BC = 2;
    localparam int LZ = 1;
    localparam int FRAME = 4 * DC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] hex_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  en_in = 4'h0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    sseg_scan_controller #(
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC),
        .LZ_BLANK    (LZ)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .en_in     (en_in),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .an        (an),
        .sseg      (sseg),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: k = cycles since the reset edge; position within the
    // frame follows from k by plain arithmetic.
    int          k = 0;
    int          cyc = 0;
    int          last_tick = -1;
    logic        m_pend = 1'b0;
    logic [15:0] m_phex = 16'h0, m_ahex = 16'h0;
    logic [3:0]  m_pdp = 4'h0, m_adp = 4'h0;
    logic [3:0]  m_pen = 4'h0, m_aen = 4'h0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d (k=%0d): got %0h expected %0h", tag, cyc, k, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] h, input int j);
        logic [15:0] t;
        t = h >> (4 * j);
        return t[3:0];
    endfunction

    function automatic logic visible(input int i);
        if (!m_aen[i]) return 1'b0;
        if (i == 0 || LZ == 0) return 1'b1;
        for (int j = i; j < 4; j++)
            if (nib(m_ahex, j) != 4'h0 || m_adp[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic compare_outputs();
        int   p, dig;
        logic show;
        logic [3:0] e_an;
        p    = k % FRAME;
        dig  = p / DC;
        show = (p % DC) >= BC;
        e_an = 4'hF;
        if (show && visible(dig)) begin
            e_an[dig] = 1'b0;
            check("sseg_digit", {24'h0, sseg}, {24'h0, ~m_adp[dig], seg_tab[nib(m_ahex, dig)]});
        end else if (!show) begin
            check("sseg_blank", {24'h0, sseg}, 32'hFF);
        end
        check("an", {28'h0, an}, {28'h0, e_an});
        check("frame_tick", {31'h0, frame_tick}, {31'h0, (p == 0 && k != 0)});
        check("upd_ready", {31'h0, upd_ready}, {31'h0, !m_pend});
    endtask

    task automatic step(input logic rst, input logic vld, input logic [15:0] h,
                        input logic [3:0] d, input logic [3:0] e);
        reset = rst; upd_valid = vld; hex_in = h; dp_in = d; en_in = e;
        if (rst) begin
            k = 0; m_pend = 1'b0;
            m_ahex = 16'h0; m_adp = 4'h0; m_aen = 4'h0;
            last_tick = -1;
        end else begin
            logic acc;
            acc = vld && !m_pend;
            if ((k % FRAME) == FRAME - 1 && m_pend) begin
                m_ahex = m_phex; m_adp = m_pdp; m_aen = m_pen; m_pend = 1'b0;
            end
            if (acc) begin
                m_phex = h; m_pdp = d; m_pen = e; m_pend = 1'b1;
            end
            k++;
        end
        @(posedge clk);
        #1;
        cyc++;
        compare_outputs();
        if (frame_tick) begin
            if (last_tick >= 0) check("tick_period", cyc - last_tick, FRAME);
            last_tick = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic run_to(input int p);
        int n = 0;
        while ((k % FRAME) != p && n < 2 * FRAME) begin
            idle(1);
            n++;
        end
        check("run_to_bound", {31'h0, (k % FRAME) == p}, 32'h1);
    endtask

    task automatic send(input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
        int n = 0;
        while (m_pend && n < 4 * FRAME) begin
            idle(1);
            n++;
        end
        check("send_ready_bound", {31'h0, m_pend}, 32'h0);
        step(1'b0, 1'b1, h, d, e);
    endtask

    initial begin
        // reset held for three cycles, then idle with nothing enabled
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(40);

        send(16'h1234, 4'h0, 4'hF);
        idle(2 * FRAME);

        send(16'h0005, 4'h0, 4'hF);
        idle(2 * FRAME);
        send(16'h0005, 4'b0100, 4'hF);
        idle(2 * FRAME);

        // two offers mid-frame: only the first is taken
        run_to(10);
        step(1'b0, 1'b1, 16'h1111, 4'h0, 4'hF);
        idle(2);
        step(1'b0, 1'b1, 16'h2222, 4'h0, 4'hF);
        idle(3 * FRAME);

        send(16'h8888, 4'h0, 4'b0101);
        idle(3 * FRAME);

        // reset in the middle of digit 2 SHOW while an update is pending
        run_to(17);
        send(16'hABCD, 4'hF, 4'hF);
        run_to(20);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        idle(2 * FRAME);

        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic        r, v;
            logic [15:0] h;
            logic [3:0]  d, e;
            r = ($urandom_range(0, 599) == 0);
            v = ($urandom_range(0, 3) == 0);
            h = 16'($urandom) >> (4 * $urandom_range(0, 4));
            d = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            e = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            step(r, v, h, d, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
